// File: rtl/deser_pkg.sv
// Shared types and helpers for the multilane deserializer.
package deser_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAcc,
      StFull
   } deser_state_e;

   // Width needed to count 0..beats inclusive.
   function automatic int unsigned len_w(input int unsigned beats);
      return $clog2(beats + 1);
   endfunction

endpackage

// File: rtl/multilane_deserializer_if.sv
// Beat-input / word-output bus of the multilane deserializer.
interface multilane_deserializer_if import deser_pkg::*; #(
   parameter int unsigned DATA_O_W = 16,
   parameter int unsigned LANE_W   = 1
);
   localparam int unsigned LEN_W = len_w(DATA_O_W / LANE_W);

   logic [LANE_W-1:0]   data_i;
   logic                data_val_i;
   logic                data_rdy_o;
   logic                msb_first_i;
   logic                flush_i;
   logic [DATA_O_W-1:0] deser_data_o;
   logic [LEN_W-1:0]    deser_data_len_o;
   logic                deser_data_val_o;
   logic                deser_data_rdy_i;

   // Upstream beat source and downstream word sink.
   modport master (
      output data_i, data_val_i, msb_first_i, flush_i, deser_data_rdy_i,
      input  data_rdy_o, deser_data_o, deser_data_len_o, deser_data_val_o
   );

   modport slave (
      input  data_i, data_val_i, msb_first_i, flush_i, deser_data_rdy_i,
      output data_rdy_o, deser_data_o, deser_data_len_o, deser_data_val_o
   );
endinterface

// File: rtl/deser_out_stage.sv
// Output word register; holds word, length and valid until the sink accepts.
module deser_out_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 3
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              free_o,
   output logic [DATA_W-1:0] data_o,
   output logic [LEN_W-1:0]  len_o,
   output logic              val_o,
   input  logic              rdy_i
);
   logic [DATA_W-1:0] data_q;
   logic [LEN_W-1:0]  len_q;
   logic              val_q;

   // Register may take a new word when empty or emptying this cycle.
   assign free_o = !val_q || rdy_i;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         data_q <= '0;
         len_q  <= '0;
         val_q  <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         len_q  <= len_i;
         val_q  <= 1'b1;
      end else if (rdy_i) begin
         val_q <= 1'b0;
      end
   end

   assign data_o = data_q;
   assign len_o  = len_q;
   assign val_o  = val_q;
endmodule

// File: rtl/multilane_deserializer.sv
// Packs LANE_W-bit beats into DATA_O_W-bit words, MSB- or LSB-first, with flush
// of partial words and a valid/ready output stage.
module multilane_deserializer import deser_pkg::*; #(
   parameter int unsigned DATA_O_W = 16,
   parameter int unsigned LANE_W   = 1
) (
   input logic                     clk_i,
   input logic                     arst_i,
   multilane_deserializer_if.slave bus
);
   localparam int unsigned     BEATS     = DATA_O_W / LANE_W;
   localparam int unsigned     LEN_W     = len_w(BEATS);
   localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(BEATS - 1);

   deser_state_e        state_q;
   logic [LEN_W-1:0]    cnt_q, cnt_nxt;
   logic [DATA_O_W-1:0] acc_q, acc_nxt, beat_word;
   logic                msb_q, msb_cur, data_rdy_q;
   logic                beat_fire, complete, out_free, load;
   logic [31:0]         shamt;

   always_comb begin
      beat_fire = bus.data_val_i && data_rdy_q;
      // The first beat of a word uses the live packing order; later beats the latched one.
      msb_cur   = (cnt_q == '0) ? bus.msb_first_i : msb_q;
      shamt     = msb_cur ? (BEATS - 1 - 32'(cnt_q)) * LANE_W : 32'(cnt_q) * LANE_W;
      beat_word = beat_fire ? (DATA_O_W'(bus.data_i) << shamt) : '0;
      acc_nxt   = acc_q | beat_word;
      cnt_nxt   = cnt_q + LEN_W'(beat_fire);
      complete  = (state_q != StFull) &&
                  ((beat_fire && cnt_q == LAST_BEAT) || (bus.flush_i && cnt_nxt != '0));
      // In FULL no beat is accepted, so acc_nxt/cnt_nxt equal the held word.
      load      = out_free && (complete || state_q == StFull);
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         msb_q      <= 1'b0;
         data_rdy_q <= 1'b0;
      end else begin
         data_rdy_q <= 1'b1;
         if (beat_fire && cnt_q == '0) begin
            msb_q <= bus.msb_first_i;
         end
         if (load) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
         end else if (complete) begin
            state_q    <= StFull;
            cnt_q      <= cnt_nxt;
            acc_q      <= acc_nxt;
            data_rdy_q <= 1'b0;
         end else if (state_q == StFull) begin
            data_rdy_q <= 1'b0;
         end else if (beat_fire) begin
            state_q <= StAcc;
            cnt_q   <= cnt_nxt;
            acc_q   <= acc_nxt;
         end
      end
   end

   assign bus.data_rdy_o = data_rdy_q;

   deser_out_stage #(
      .DATA_W (DATA_O_W),
      .LEN_W  (LEN_W)
   ) u_out_stage (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .load_i (load),
      .data_i (acc_nxt),
      .len_i  (cnt_nxt),
      .free_o (out_free),
      .data_o (bus.deser_data_o),
      .len_o  (bus.deser_data_len_o),
      .val_o  (bus.deser_data_val_o),
      .rdy_i  (bus.deser_data_rdy_i)
   );
endmodule

// File: tb/tb_multilane_deserializer.sv
// Directed self-checking bench: 16/4 instance for packing, flush, backpressure and
// reset; 8/1 instance for continuous random streaming.
module tb_multilane_deserializer;
   logic clk  = 1'b0;
   logic arst = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   multilane_deserializer_if #(.DATA_O_W(16), .LANE_W(4)) bus16 ();
   multilane_deserializer_if #(.DATA_O_W(8), .LANE_W(1)) bus8 ();

   multilane_deserializer #(.DATA_O_W(16), .LANE_W(4)) u_dut16 (
      .clk_i  (clk),
      .arst_i (arst),
      .bus    (bus16)
   );

   multilane_deserializer #(.DATA_O_W(8), .LANE_W(1)) u_dut8 (
      .clk_i  (clk),
      .arst_i (arst),
      .bus    (bus8)
   );

   task automatic beat16(input logic [3:0] d, input logic msb, input logic fl);
      bus16.data_i      = d;
      bus16.data_val_i  = 1'b1;
      bus16.msb_first_i = msb;
      bus16.flush_i     = fl;
      @(posedge clk); #1;
      bus16.data_val_i  = 1'b0;
      bus16.flush_i     = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      #1;
      n_checks++;
      if (bus16.data_rdy_o !== 1'b0) $display("FAIL reset_rdy16: got %b want 0", bus16.data_rdy_o);
      else n_pass++;
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b0 || bus16.deser_data_len_o !== 3'd0 ||
          bus16.deser_data_o !== 16'h0)
         $display("FAIL reset_out16: got val=%b len=%0d data=%h want 0/0/0000",
                  bus16.deser_data_val_o, bus16.deser_data_len_o, bus16.deser_data_o);
      else n_pass++;
      n_checks++;
      if (bus8.data_rdy_o !== 1'b0 || bus8.deser_data_val_o !== 1'b0 || bus8.deser_data_o !== 8'h0)
         $display("FAIL reset_out8: got rdy=%b val=%b data=%h want 0/0/00",
                  bus8.data_rdy_o, bus8.deser_data_val_o, bus8.deser_data_o);
      else n_pass++;
      @(posedge clk); #1;
      arst = 1'b0;
      #1;
      n_checks++;
      if (bus16.data_rdy_o !== 1'b0) $display("FAIL rdy_before_clk: got %b want 0", bus16.data_rdy_o);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bus16.data_rdy_o !== 1'b1 || bus8.data_rdy_o !== 1'b1)
         $display("FAIL rdy_after_clk: got %b/%b want 1/1", bus16.data_rdy_o, bus8.data_rdy_o);
      else n_pass++;
   endtask

   task automatic test_msb_first();
      beat16(4'h1, 1'b1, 1'b0);
      beat16(4'h2, 1'b1, 1'b0);
      beat16(4'h3, 1'b1, 1'b0);
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b0) $display("FAIL msb_val_early: got %b want 0", bus16.deser_data_val_o);
      else n_pass++;
      beat16(4'h4, 1'b1, 1'b0);
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b1 || bus16.deser_data_o !== 16'h1234 ||
          bus16.deser_data_len_o !== 3'd4)
         $display("FAIL msb_word: got val=%b data=%h len=%0d want 1/1234/4",
                  bus16.deser_data_val_o, bus16.deser_data_o, bus16.deser_data_len_o);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b0) $display("FAIL msb_pulse: got %b want 0", bus16.deser_data_val_o);
      else n_pass++;
   endtask

   task automatic test_lsb_first();
      beat16(4'h1, 1'b0, 1'b0);
      beat16(4'h2, 1'b1, 1'b0);
      beat16(4'h3, 1'b1, 1'b0);
      beat16(4'h4, 1'b0, 1'b0);
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b1 || bus16.deser_data_o !== 16'h4321 ||
          bus16.deser_data_len_o !== 3'd4)
         $display("FAIL lsb_word: got val=%b data=%h len=%0d want 1/4321/4",
                  bus16.deser_data_val_o, bus16.deser_data_o, bus16.deser_data_len_o);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      beat16(4'hA, 1'b1, 1'b0);
      beat16(4'hB, 1'b0, 1'b0);
      beat16(4'hC, 1'b0, 1'b1);
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b1 || bus16.deser_data_o !== 16'hABC0 ||
          bus16.deser_data_len_o !== 3'd3)
         $display("FAIL flush_word: got val=%b data=%h len=%0d want 1/abc0/3",
                  bus16.deser_data_val_o, bus16.deser_data_o, bus16.deser_data_len_o);
      else n_pass++;
      @(posedge clk); #1;
      // Flush with nothing held and nothing offered.
      bus16.flush_i = 1'b1;
      @(posedge clk); #1;
      bus16.flush_i = 1'b0;
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b0 || bus16.data_rdy_o !== 1'b1)
         $display("FAIL flush_idle: got val=%b rdy=%b want 0/1", bus16.deser_data_val_o, bus16.data_rdy_o);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b0) $display("FAIL flush_idle_late: got %b want 0", bus16.deser_data_val_o);
      else n_pass++;
      beat16(4'hD, 1'b1, 1'b1);
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b1 || bus16.deser_data_o !== 16'hD000 ||
          bus16.deser_data_len_o !== 3'd1)
         $display("FAIL flush_single: got val=%b data=%h len=%0d want 1/d000/1",
                  bus16.deser_data_val_o, bus16.deser_data_o, bus16.deser_data_len_o);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [3:0]  bts [0:11];
      logic [15:0] exp_w [0:2];
      logic [15:0] got [$];
      int          idx = 0;
      int          unstable = 0;
      logic        acc;
      for (int i = 0; i < 12; i++) bts[i] = 4'(i + 1);
      exp_w[0] = 16'h1234;
      exp_w[1] = 16'h5678;
      exp_w[2] = 16'h9ABC;
      bus16.deser_data_rdy_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
         bus16.data_val_i  = (idx < 12);
         bus16.data_i      = bts[idx % 12];
         bus16.msb_first_i = 1'b1;
         acc = bus16.data_val_i && bus16.data_rdy_o;
         if (bus16.deser_data_val_o && bus16.deser_data_o !== 16'h1234) unstable++;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      n_checks++;
      if (idx != 8) $display("FAIL bp_accepted: got %0d beats want 8", idx);
      else n_pass++;
      n_checks++;
      if (bus16.data_rdy_o !== 1'b0) $display("FAIL bp_rdy_full: got %b want 0", bus16.data_rdy_o);
      else n_pass++;
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b1 || bus16.deser_data_o !== 16'h1234 || unstable != 0)
         $display("FAIL bp_hold: got val=%b data=%h unstable=%0d want 1/1234/0",
                  bus16.deser_data_val_o, bus16.deser_data_o, unstable);
      else n_pass++;
      bus16.deser_data_rdy_i = 1'b1;
      for (int c = 0; c < 30; c++) begin
         bus16.data_val_i = (idx < 12);
         bus16.data_i     = bts[idx % 12];
         acc = bus16.data_val_i && bus16.data_rdy_o;
         if (bus16.deser_data_val_o) got.push_back(bus16.deser_data_o);
         @(posedge clk); #1;
         if (acc) idx++;
      end
      bus16.data_val_i = 1'b0;
      n_checks++;
      if (got.size() != 3) $display("FAIL bp_count: got %0d words want 3", got.size());
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (k >= got.size() || got[k] !== exp_w[k])
            $display("FAIL bp_word%0d: got %h want %h", k, (k < got.size()) ? got[k] : 16'hxxxx, exp_w[k]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      beat16(4'h5, 1'b1, 1'b0);
      beat16(4'h6, 1'b1, 1'b0);
      #2;
      arst = 1'b1;
      #1;
      n_checks++;
      if (bus16.data_rdy_o !== 1'b0 || bus16.deser_data_val_o !== 1'b0 ||
          bus16.deser_data_len_o !== 3'd0 || bus16.deser_data_o !== 16'h0)
         $display("FAIL midreset_out: got rdy=%b val=%b len=%0d data=%h want 0/0/0/0000",
                  bus16.data_rdy_o, bus16.deser_data_val_o, bus16.deser_data_len_o, bus16.deser_data_o);
      else n_pass++;
      @(posedge clk); #1;
      arst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus16.data_rdy_o !== 1'b1) $display("FAIL midreset_rdy: got %b want 1", bus16.data_rdy_o);
      else n_pass++;
      beat16(4'h7, 1'b1, 1'b0);
      beat16(4'h8, 1'b1, 1'b0);
      beat16(4'h9, 1'b1, 1'b0);
      beat16(4'hA, 1'b1, 1'b0);
      n_checks++;
      if (bus16.deser_data_val_o !== 1'b1 || bus16.deser_data_o !== 16'h789A ||
          bus16.deser_data_len_o !== 3'd4)
         $display("FAIL midreset_word: got val=%b data=%h len=%0d want 1/789a/4",
                  bus16.deser_data_val_o, bus16.deser_data_o, bus16.deser_data_len_o);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic       bitv [0:79];
      logic       msbv [0:9];
      logic [7:0] exp_w [0:9];
      logic [7:0] got [$];
      int         pos [$];
      int         bubbles = 0;
      int         len_bad = 0;
      for (int w = 0; w < 10; w++) begin
         msbv[w]  = w[0];
         exp_w[w] = 8'h00;
         for (int k = 0; k < 8; k++) begin
            bitv[w*8+k] = 1'($urandom_range(0, 1));
            if (msbv[w]) exp_w[w][7-k] = bitv[w*8+k];
            else exp_w[w][k] = bitv[w*8+k];
         end
      end
      bus8.deser_data_rdy_i = 1'b1;
      for (int i = 0; i < 83; i++) begin
         if (i < 80) begin
            bus8.data_val_i = 1'b1;
            bus8.data_i[0]  = bitv[i];
            // Only the first beat's order should matter; the rest see the opposite.
            bus8.msb_first_i = (i % 8 == 0) ? msbv[i/8] : !msbv[i/8];
            if (!bus8.data_rdy_o) bubbles++;
         end else begin
            bus8.data_val_i = 1'b0;
         end
         if (bus8.deser_data_val_o) begin
            got.push_back(bus8.deser_data_o);
            pos.push_back(i);
            if (bus8.deser_data_len_o !== 4'd8) len_bad++;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (bubbles != 0 || len_bad != 0)
         $display("FAIL b2b_flow: got bubbles=%0d bad_len=%0d want 0/0", bubbles, len_bad);
      else n_pass++;
      n_checks++;
      if (got.size() != 10) $display("FAIL b2b_count: got %0d words want 10", got.size());
      else n_pass++;
      for (int w = 0; w < 10; w++) begin
         n_checks++;
         if (w >= got.size() || got[w] !== exp_w[w] || pos[w] != 8 * (w + 1))
            $display("FAIL b2b_word%0d: got %h at cycle %0d want %h at cycle %0d", w,
                     (w < got.size()) ? got[w] : 8'hxx, (w < pos.size()) ? pos[w] : -1,
                     exp_w[w], 8 * (w + 1));
         else n_pass++;
      end
   endtask

   initial begin
      bus16.data_i = '0;  bus16.data_val_i = 1'b0; bus16.msb_first_i = 1'b0;
      bus16.flush_i = 1'b0; bus16.deser_data_rdy_i = 1'b1;
      bus8.data_i = '0;   bus8.data_val_i = 1'b0;  bus8.msb_first_i = 1'b0;
      bus8.flush_i = 1'b0;  bus8.deser_data_rdy_i = 1'b1;
      #1;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_flush();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end
endmodule
